// File: rtl/buffer_frame_reader_if.sv
// Signal bundle between the frame reader, the sample buffer read port and the
// FFT-side sample stream consumer.
//
// Stream handshake: a sample transfers on a rising mclk edge where both
// sample_valid_o and sample_ready_i are 1. Once valid is raised, sample_o and
// sample_last_o stay stable and valid stays high until that transfer occurs.
interface buffer_frame_reader_if #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10
);
  logic                 start_i;
  logic [ADDR_BITS-1:0] base_addr_i;
  logic [ADDR_BITS-1:0] buffer_raddr_o;
  logic [DATA_BITS-1:0] buffer_rdata_i;
  logic                 buffer_available_i;
  logic [DATA_BITS-1:0] sample_o;
  logic                 sample_valid_o;
  logic                 sample_ready_i;
  logic                 sample_last_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  modport master (
    input  start_i,
    input  base_addr_i,
    input  buffer_rdata_i,
    input  buffer_available_i,
    input  sample_ready_i,
    output buffer_raddr_o,
    output sample_o,
    output sample_valid_o,
    output sample_last_o,
    output busy_o,
    output done_o,
    output err_o
  );

  modport slave (
    output start_i,
    output base_addr_i,
    output buffer_rdata_i,
    output buffer_available_i,
    output sample_ready_i,
    input  buffer_raddr_o,
    input  sample_o,
    input  sample_valid_o,
    input  sample_last_o,
    input  busy_o,
    input  done_o,
    input  err_o
  );
endinterface

// File: rtl/buffer_frame_reader.sv
// Read-side master of the codec sample buffer: fetches FRAME_LEN consecutive
// samples from a base address and streams them to the FFT front end.
module buffer_frame_reader #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10,
  parameter int FRAME_LEN = 256,
  parameter int STALL_MAX = 4095
) (
  input  logic                mclk,
  input  logic                rst_n,
  buffer_frame_reader_if.master bus,
  output logic [2:0]          dbg_state_o
);

  localparam int SMP_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  localparam logic [SMP_W-1:0]   LAST_IDX  = SMP_W'(FRAME_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [STALL_W-1:0]   stall_inc;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  assign stall_inc = stall_cnt_q + STALL_W'(1);

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      smp_cnt_q   <= '0;
      stall_cnt_q <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      smp_cnt_q   <= smp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    smp_cnt_d   = smp_cnt_q;
    stall_cnt_d = stall_cnt_q;
    sample_d    = sample_q;
    valid_d     = valid_q;
    last_d      = last_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          rd_ptr_d    = bus.base_addr_i;
          smp_cnt_d   = '0;
          stall_cnt_d = '0;
          state_d     = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus.buffer_available_i) begin
          stall_cnt_d = '0;
          state_d     = S_WAIT;
        end else if (stall_inc == STALL_LIM) begin
          // Give up on the frame: err_o is a registered pulse seen in IDLE.
          stall_cnt_d = '0;
          err_d       = 1'b1;
          state_d     = S_IDLE;
        end else begin
          stall_cnt_d = stall_inc;
        end
      end

      // The buffer returns data one cycle after the address; capture it here.
      S_WAIT: begin
        sample_d = bus.buffer_rdata_i;
        valid_d  = 1'b1;
        last_d   = (smp_cnt_q == LAST_IDX);
        state_d  = S_OUT;
      end

      S_OUT: begin
        if (bus.sample_ready_i) begin
          valid_d   = 1'b0;
          last_d    = 1'b0;
          rd_ptr_d  = rd_ptr_q + ADDR_BITS'(1);
          smp_cnt_d = smp_cnt_q + SMP_W'(1);
          state_d   = last_q ? S_DONE : S_ADDR;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.buffer_raddr_o = rd_ptr_q;
  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.sample_last_o  = last_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.done_o         = (state_q == S_DONE);
  assign bus.err_o          = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_buffer_frame_reader.sv
// Directed bench for buffer_frame_reader with FRAME_LEN=4, STALL_MAX=8 and a
// behavioural buffer holding addr+100 at every address.
module tb_buffer_frame_reader;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          mclk;
  logic          rst_n;
  logic [2:0]    dbg_state;

  buffer_frame_reader_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  buffer_frame_reader #(
    .DATA_BITS(DW),
    .ADDR_BITS(AW),
    .FRAME_LEN(4),
    .STALL_MAX(8)
  ) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Buffer model: read data valid one cycle after the address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 100);
  end
  always @(posedge mclk) bus.buffer_rdata_i <= mem[bus.buffer_raddr_o];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-frame observations
  int            hs_cyc[$];
  logic [DW-1:0] hs_data[$];
  logic [AW-1:0] hs_addr[$];
  logic          hs_last[$];
  logic [DW-1:0] exp_q[$];
  int            done_cyc, err_cyc, n_done, n_err, n_valid, busy_cnt;
  int            stall_cycles, viol;
  logic          timed_out, idle_after;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: launches a frame in the current cycle (cycle 0) and monitors it.
  task automatic run_frame(input logic [AW-1:0] base, input int hold_idx, input int hold_n,
                           input int avail_low, input int restart_cyc);
    int            held, end_cyc;
    logic          prev_stall, prev_last;
    logic [DW-1:0] prev_sample;
    logic [AW-1:0] prev_addr;
    hs_cyc.delete(); hs_data.delete(); hs_addr.delete(); hs_last.delete();
    done_cyc = -1; err_cyc = -1; n_done = 0; n_err = 0; n_valid = 0; busy_cnt = 0;
    stall_cycles = 0; viol = 0; timed_out = 1'b0; idle_after = 1'b0;
    held = 0; end_cyc = -1; prev_stall = 1'b0; prev_last = 1'b0;
    prev_sample = '0; prev_addr = '0;
    bus.base_addr_i        = base;
    bus.start_i            = 1'b1;
    bus.buffer_available_i = 1'b1;
    bus.sample_ready_i     = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == restart_cyc) begin
        bus.start_i = 1'b1; bus.base_addr_i = AW'(500);
      end else begin
        bus.start_i = 1'b0; bus.base_addr_i = base;
      end
      bus.buffer_available_i = (cyc > avail_low);
      if (bus.sample_valid_o && hs_cyc.size() == hold_idx && held < hold_n) begin
        bus.sample_ready_i = 1'b0; held++; stall_cycles++;
      end else begin
        bus.sample_ready_i = 1'b1;
      end
      if (prev_stall && (bus.sample_o !== prev_sample || bus.buffer_raddr_o !== prev_addr ||
                         bus.sample_valid_o !== 1'b1 || bus.sample_last_o !== prev_last))
        viol++;
      prev_stall  = bus.sample_valid_o && !bus.sample_ready_i;
      prev_sample = bus.sample_o;
      prev_addr   = bus.buffer_raddr_o;
      prev_last   = bus.sample_last_o;
      if (bus.busy_o) busy_cnt++;
      if (bus.sample_valid_o) n_valid++;
      if (bus.sample_valid_o && bus.sample_ready_i) begin
        hs_cyc.push_back(cyc);
        hs_data.push_back(bus.sample_o);
        hs_addr.push_back(bus.buffer_raddr_o);
        hs_last.push_back(bus.sample_last_o);
      end
      if (bus.done_o) begin n_done++; done_cyc = cyc; end
      if (bus.err_o)  begin n_err++;  err_cyc  = cyc; end
      if (bus.done_o || bus.err_o) end_cyc = cyc;
      else if (end_cyc >= 0) begin
        idle_after = !bus.busy_o && !bus.sample_valid_o;
        break;
      end
      tick();
    end
    bus.start_i = 1'b0;
    bus.buffer_available_i = 1'b1;
    bus.sample_ready_i = 1'b1;
    if (end_cyc < 0 || !idle_after) timed_out = (end_cyc < 0);
  endtask

  // Scoreboard for one completed 4-sample frame.
  task automatic check_frame(input string tag, input logic [AW-1:0] base,
                             input int c0, input int c1, input int c2, input int c3,
                             input int done_c);
    int            exp_cyc[4];
    logic [AW-1:0] a;
    exp_cyc = '{c0, c1, c2, c3};
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      a = base + AW'(i);
      exp_q.push_back(DW'(a) + DW'(100));
    end
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_n_samples"}, hs_cyc.size(), 4);
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++) begin
      a = base + AW'(i);
      check($sformatf("%s_cyc%0d", tag, i),  hs_cyc[i],  exp_cyc[i]);
      check($sformatf("%s_data%0d", tag, i), hs_data[i], exp_q.pop_front());
      check($sformatf("%s_addr%0d", tag, i), hs_addr[i], a);
      check($sformatf("%s_last%0d", tag, i), hs_last[i], (i == 3));
    end
    check({tag, "_done_cyc"}, done_cyc, done_c);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_n_err"}, n_err, 0);
    check({tag, "_idle_after"}, idle_after, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_raddr"}, bus.buffer_raddr_o, 0);
    check({tag, "_sample"}, bus.sample_o, 0);
    check({tag, "_valid"}, bus.sample_valid_o, 0);
    check({tag, "_last"}, bus.sample_last_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.base_addr_i = '0;
    bus.buffer_available_i = 1'b1;
    bus.sample_ready_i = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic frame: samples at 3,6,9,12, done at 13, busy 1..13.
    run_frame(AW'(10), -1, 0, 0, -1);
    check_frame("basic", AW'(10), 3, 6, 9, 12, 13);
    check("basic_busy_cycles", busy_cnt, 13);
    check("basic_n_valid", n_valid, 4);

    // Address wrap 1022,1023,0,1; started the cycle after done.
    run_frame(AW'(1022), -1, 0, 0, -1);
    check_frame("wrap", AW'(1022), 3, 6, 9, 12, 13);

    // Backpressure: ready low 5 cycles on sample 2.
    run_frame(AW'(10), 2, 5, 0, -1);
    check_frame("bp", AW'(10), 3, 6, 14, 17, 18);
    check("bp_stall_cycles", stall_cycles, 5);
    check("bp_hold_violations", viol, 0);

    // Availability low for 7 ADDR cycles: 7 cycles late, no error.
    run_frame(AW'(10), -1, 0, 7, -1);
    check_frame("avail7", AW'(10), 10, 13, 16, 19, 20);

    // Availability low for 8+ cycles: err_o in cycle 9, nothing streamed.
    run_frame(AW'(10), -1, 0, 10, -1);
    check("stall_timeout", timed_out, 0);
    check("stall_err_cyc", err_cyc, 9);
    check("stall_n_err", n_err, 1);
    check("stall_n_done", n_done, 0);
    check("stall_n_valid", n_valid, 0);
    check("stall_busy_cycles", busy_cnt, 8);
    check("stall_idle_after", idle_after, 1);

    // Start while busy is ignored.
    run_frame(AW'(10), -1, 0, 0, 5);
    check_frame("restart", AW'(10), 3, 6, 9, 12, 13);

    // Reset during OUT of sample 2 (cycle 9).
    bus.base_addr_i = AW'(10);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check("midrst_pre_valid", bus.sample_valid_o, 1);
    check("midrst_pre_sample", bus.sample_o, 112);
    rst_n = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    run_frame(AW'(10), -1, 0, 0, -1);
    check_frame("after_rst", AW'(10), 3, 6, 9, 12, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
